// File: rtl/decode_stage.sv
// decode_stage
//   RV32I decode stage with one registered output slot. Decodes the incoming
//   instruction word into ALU function, operand selects, sign-extended
//   immediate, register addresses and control flags for the execute stage.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the held and the incoming instruction
//   in_valid/in_ready   fetch-side handshake, in_pc/in_inst payload
//   out_valid/out_ready execute-side handshake
//   out_*               registered decode results (don't-care when !out_valid)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so a held instruction being
// consumed frees the slot in the same edge (no bubble). in_ready never looks
// at in_valid. flush and rst win over any accept in the same cycle.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          out_alu_fn,
  output logic [1:0]          out_op1_sel,
  output logic                out_op2_sel,
  output logic [XLEN-1:0]     out_imm,
  output logic [ADDR_LEN-1:0] out_rs1,
  output logic [ADDR_LEN-1:0] out_rs2,
  output logic [ADDR_LEN-1:0] out_rd,
  output logic [2:0]          out_funct3,
  output logic                out_rf_wen,
  output logic                out_mem_ren,
  output logic                out_mem_wen,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_illegal
);

  // ALU function codes shared with the execute stage
  localparam logic [4:0] ALU_X    = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_JALR = 5'd11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  // funct3 -> ALU code for OP and OP-IMM. SUB only exists in the register form.
  function automatic logic [4:0] arith_fn(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    logic [4:0] fn;
    fn = ALU_X;
    case (f3)
      3'b000:  fn = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  fn = ALU_SLL;
      3'b010:  fn = ALU_SLT;
      3'b011:  fn = ALU_SLTU;
      3'b100:  fn = ALU_XOR;
      3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
    return fn;
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]      opcode;

  assign opcode = in_inst[6:0];
  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};

  logic [4:0]      alu_fn_d;
  logic [1:0]      op1_sel_d;
  logic            op2_sel_d;
  logic [XLEN-1:0] imm_d;
  logic            rf_wen_raw, mem_ren_d, mem_wen_d, branch_d, jump_d, illegal_d;

  always_comb begin
    alu_fn_d   = ALU_X;
    op1_sel_d  = OP1_RS1;
    op2_sel_d  = 1'b0;
    imm_d      = '0;
    rf_wen_raw = 1'b0;
    mem_ren_d  = 1'b0;
    mem_wen_d  = 1'b0;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    illegal_d  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_fn_d = ALU_ADD; op1_sel_d = OP1_ZERO; op2_sel_d = 1'b1;
        imm_d = imm_u; rf_wen_raw = 1'b1;
      end
      OPC_AUIPC: begin
        alu_fn_d = ALU_ADD; op1_sel_d = OP1_PC; op2_sel_d = 1'b1;
        imm_d = imm_u; rf_wen_raw = 1'b1;
      end
      OPC_JAL: begin
        alu_fn_d = ALU_ADD; op1_sel_d = OP1_PC; op2_sel_d = 1'b1;
        imm_d = imm_j; rf_wen_raw = 1'b1; jump_d = 1'b1;
      end
      OPC_JALR: begin
        alu_fn_d = ALU_JALR; op2_sel_d = 1'b1;
        imm_d = imm_i; rf_wen_raw = 1'b1; jump_d = 1'b1;
      end
      OPC_BRANCH: begin
        alu_fn_d = ALU_ADD; op1_sel_d = OP1_PC; op2_sel_d = 1'b1;
        imm_d = imm_b; branch_d = 1'b1;
      end
      OPC_LOAD: begin
        alu_fn_d = ALU_ADD; op2_sel_d = 1'b1;
        imm_d = imm_i; rf_wen_raw = 1'b1; mem_ren_d = 1'b1;
      end
      OPC_STORE: begin
        alu_fn_d = ALU_ADD; op2_sel_d = 1'b1;
        imm_d = imm_s; mem_wen_d = 1'b1;
      end
      OPC_OPIMM: begin
        alu_fn_d = arith_fn(in_inst[14:12], in_inst[30], 1'b0);
        op2_sel_d = 1'b1; imm_d = imm_i; rf_wen_raw = 1'b1;
      end
      OPC_OP: begin
        alu_fn_d = arith_fn(in_inst[14:12], in_inst[30], 1'b1);
        rf_wen_raw = 1'b1;
      end
      OPC_MISC, OPC_SYSTEM: begin
        alu_fn_d = ALU_X;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic                accept;
  logic                valid_q;
  logic [XLEN-1:0]     pc_q, imm_q;
  logic [4:0]          alu_fn_q;
  logic [1:0]          op1_sel_q;
  logic                op2_sel_q;
  logic [ADDR_LEN-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]          funct3_q;
  logic                rf_wen_q, mem_ren_q, mem_wen_q, branch_q, jump_q, illegal_q;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      alu_fn_q  <= ALU_X;
      op1_sel_q <= '0;
      op2_sel_q <= 1'b0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      rf_wen_q  <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      branch_q  <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= in_pc;
      alu_fn_q  <= alu_fn_d;
      op1_sel_q <= op1_sel_d;
      op2_sel_q <= op2_sel_d;
      imm_q     <= imm_d;
      rs1_q     <= in_inst[19:15];
      rs2_q     <= in_inst[24:20];
      rd_q      <= in_inst[11:7];
      funct3_q  <= in_inst[14:12];
      // writes to x0 are architecturally void, so never request them
      rf_wen_q  <= rf_wen_raw && (in_inst[11:7] != 5'd0);
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      branch_q  <= branch_d;
      jump_q    <= jump_d;
      illegal_q <= illegal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_alu_fn  = alu_fn_q;
  assign out_op1_sel = op1_sel_q;
  assign out_op2_sel = op2_sel_q;
  assign out_imm     = imm_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;
  assign out_funct3  = funct3_q;
  assign out_rf_wen  = rf_wen_q;
  assign out_mem_ren = mem_ren_q;
  assign out_mem_wen = mem_wen_q;
  assign out_branch  = branch_q;
  assign out_jump    = jump_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Scoreboard bench for decode_stage. Driver tasks push the hand-computed
//   decode of each accepted instruction; a monitor pops and compares every
//   time the stage hands an instruction to execute.
module tb_decode_stage;

  localparam logic [4:0] ALU_X    = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_JALR = 5'd11;

  localparam logic [4:0] D_IMM = 5'b00001;
  localparam logic [4:0] D_RS1 = 5'b00010;
  localparam logic [4:0] D_RS2 = 5'b00100;
  localparam logic [4:0] D_RD  = 5'b01000;
  localparam logic [4:0] D_SEL = 5'b10000;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  fn;
    logic [1:0]  op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [5:0]  flags; // rf_wen, mem_ren, mem_wen, branch, jump, illegal
  } dec_t;

  localparam int W = $bits(dec_t);

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_imm;
  logic [4:0]  out_alu_fn, out_rs1, out_rs2, out_rd;
  logic [1:0]  out_op1_sel;
  logic        out_op2_sel;
  logic [2:0]  out_funct3;
  logic        out_rf_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int checks   = 0;
  int failures = 0;

  decode_stage #(.XLEN(32), .ADDR_LEN(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_fn(out_alu_fn), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_rf_wen(out_rf_wen), .out_mem_ren(out_mem_ren),
    .out_mem_wen(out_mem_wen), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dec_t mk(input logic [31:0] pc, input logic [4:0] fn,
                              input logic [1:0] op1, input logic op2,
                              input logic [31:0] imm, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [5:0] flags);
    dec_t d;
    d.pc = pc; d.fn = fn; d.op1 = op1; d.op2 = op2; d.imm = imm;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.f3 = f3; d.flags = flags;
    return d;
  endfunction

  function automatic dec_t mkm(input logic [4:0] dc);
    dec_t m;
    m = '1;
    if (dc[0]) m.imm = '0;
    if (dc[1]) m.rs1 = '0;
    if (dc[2]) m.rs2 = '0;
    if (dc[3]) m.rd  = '0;
    if (dc[4]) begin m.op1 = '0; m.op2 = 1'b0; end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction and hold it until accepted; push its decode then.
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input dec_t e, input logic [4:0] dc);
    logic rdy;
    bit   done;
    done = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(e);
        msk_q.push_back(mkm(dc));
        done = 1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout: inst %h never accepted", inst);
    end
    #1 in_valid = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    dec_t a, e, m;
    if (!rst && out_valid && out_ready) begin
      checks++;
      a = {out_pc, out_alu_fn, out_op1_sel, out_op2_sel, out_imm, out_rs1, out_rs2,
           out_rd, out_funct3, out_rf_wen, out_mem_ren, out_mem_wen, out_branch,
           out_jump, out_illegal};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got %h expected nothing", a);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        if (((a ^ e) & m) != '0) begin
          failures++;
          $display("FAIL decode pc=%h: got %h expected %h (mask %h)", e.pc, a, e, m);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_fn", {27'b0, out_alu_fn}, {27'b0, ALU_X});
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_flags", {26'b0, out_rf_wen, out_mem_ren, out_mem_wen, out_branch,
                      out_jump, out_illegal}, 32'd0);
    @(posedge clk); #1;

    // back-to-back decode with execute always ready
    drive(32'h00500093, 32'h100, mk(32'h100, ALU_ADD, 0, 1, 32'd5, 0, 0, 1, 0, 6'b100000), D_RS2);
    drive(32'h40335293, 32'h104, mk(32'h104, ALU_SRA, 0, 1, 32'h403, 6, 0, 5, 5, 6'b100000), D_RS2);
    drive(32'h402081B3, 32'h108, mk(32'h108, ALU_SUB, 0, 0, 0, 1, 2, 3, 0, 6'b100000), D_IMM);
    drive(32'h002081B3, 32'h10C, mk(32'h10C, ALU_ADD, 0, 0, 0, 1, 2, 3, 0, 6'b100000), D_IMM);
    drive(32'h0020A423, 32'h110, mk(32'h110, ALU_ADD, 0, 1, 32'd8, 1, 2, 0, 2, 6'b001000), D_RD);
    drive(32'h123450B7, 32'h114, mk(32'h114, ALU_ADD, 2, 1, 32'h12345000, 0, 0, 1, 5, 6'b100000), D_RS1 | D_RS2);
    drive(32'h00001117, 32'h118, mk(32'h118, ALU_ADD, 1, 1, 32'h1000, 0, 0, 2, 1, 6'b100000), D_RS1 | D_RS2);
    drive(32'hFFDFF0EF, 32'h11C, mk(32'h11C, ALU_ADD, 1, 1, 32'hFFFFFFFC, 0, 0, 1, 7, 6'b100010), D_RS1 | D_RS2);
    drive(32'h00208463, 32'h120, mk(32'h120, ALU_ADD, 1, 1, 32'd8, 1, 2, 0, 0, 6'b000100), D_RD);
    drive(32'hFFC0A283, 32'h124, mk(32'h124, ALU_ADD, 0, 1, 32'hFFFFFFFC, 1, 0, 5, 2, 6'b110000), D_RS2);
    drive(32'h00008067, 32'h128, mk(32'h128, ALU_JALR, 0, 1, 0, 1, 0, 0, 0, 6'b000010), D_RS2);
    drive(32'h00000073, 32'h12C, mk(32'h12C, ALU_X, 0, 0, 0, 0, 0, 0, 0, 6'b000000),
          D_IMM | D_RS1 | D_RS2 | D_RD | D_SEL);
    drive(32'hFFFFFFFF, 32'h130, mk(32'h130, ALU_X, 0, 0, 0, 0, 0, 0, 7, 6'b000001),
          D_IMM | D_RS1 | D_RS2 | D_RD | D_SEL);
    drive(32'h00500013, 32'h134, mk(32'h134, ALU_ADD, 0, 1, 32'd5, 0, 0, 0, 0, 6'b000000), D_RS2);
    repeat (3) @(posedge clk); #1;

    // backpressure: held addi stays put while the next instruction waits
    out_ready = 1'b0;
    drive(32'h00500093, 32'h200, mk(32'h200, ALU_ADD, 0, 1, 32'd5, 0, 0, 1, 0, 6'b100000), D_RS2);
    in_valid = 1'b1; in_inst = 32'h402081B3; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_pc", out_pc, 32'h200);
      chk("bp_imm", out_imm, 32'd5);
      chk("bp_rd_fn", {22'b0, out_rd, out_alu_fn}, {22'b0, 5'd1, ALU_ADD});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(32'h402081B3, 32'h204, mk(32'h204, ALU_SUB, 0, 0, 0, 1, 2, 3, 0, 6'b100000), D_IMM);
    @(negedge clk);
    chk("no_bubble_valid", {31'b0, out_valid}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // flush while full, with a new instruction offered in the same cycle
    out_ready = 1'b0;
    drive(32'h00500093, 32'h300, mk(32'h300, ALU_ADD, 0, 1, 32'd5, 0, 0, 1, 0, 6'b100000), D_RS2);
    void'(exp_q.pop_back());
    void'(msk_q.pop_back());
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h304;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // reset while holding an instruction drops it
    out_ready = 1'b0;
    drive(32'h40335293, 32'h400, mk(32'h400, ALU_SRA, 0, 1, 32'h403, 6, 0, 5, 5, 6'b100000), D_RS2);
    void'(exp_q.pop_back());
    void'(msk_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // a couple more after reset to show the stage recovers
    drive(32'h0020A423, 32'h500, mk(32'h500, ALU_ADD, 0, 1, 32'd8, 1, 2, 0, 2, 6'b001000), D_RD);
    drive(32'h00500093, 32'h504, mk(32'h504, ALU_ADD, 0, 1, 32'd5, 0, 0, 1, 0, 6'b100000), D_RS2);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
